// File: rtl/shared_reg_pkg.sv
// Shared types and constants for shared_reg_arbiter: FSM encoding, default
// sizes, and the pointer-width helper used by the top and the selector.
package shared_reg_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 8;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t HOLD = 1'b1;

  // Index width for a requester count; a count of one still needs a 1-bit index.
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick
  import shared_reg_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = ptr_width(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            any
);

  always_comb begin
    int          sum;
    logic [PW-1:0] idx;
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    winner = '0;
    any    = 1'b0;
    sum    = 0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = PW'(sum);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one capture register between NREQ producers.
// Define SHARED_REG_BYPASS_EN to allow back-to-back captures on acknowledge.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DW-1:0]           din,
  output logic [NREQ-1:0]              gnt,
  output logic [DW-1:0]                q,
  output logic                         q_valid,
  output logic [ptr_width(NREQ)-1:0]   q_src,
  input  logic                         q_ack
);

  localparam int PW = ptr_width(NREQ);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic            any;
  logic [NREQ-1:0] eligible;
  logic [DW-1:0]   words [NREQ];
  logic            capture;
  logic [PW-1:0]   ptr_next;

  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign words[i] = din[i*DW +: DW];
  end

  // The requester granted this cycle still holds req high; mask it out.
  assign eligible = req & ~gnt;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (eligible),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

`ifdef SHARED_REG_BYPASS_EN
  assign capture = any && ((state == IDLE) || q_ack);
`else
  assign capture = any && (state == IDLE);
`endif

  assign ptr_next = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      q       <= '0;
      q_src   <= '0;
      q_valid <= 1'b0;
      gnt     <= '0;
    end else begin
      gnt <= '0;
      if (capture) begin
        q       <= words[winner];
        q_src   <= winner;
        q_valid <= 1'b1;
        gnt     <= NREQ'(1) << winner;
        ptr     <= ptr_next;
        state   <= HOLD;
      end else if (state == HOLD && q_ack) begin
        q_valid <= 1'b0;
        state   <= IDLE;
      end
    end
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_valid  : assert property (@(posedge clk) disable iff (rst) (gnt != '0) |-> q_valid);
  a_hold_valid : assert property (@(posedge clk) disable iff (rst) (state == HOLD) == q_valid);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus a random
// phase, all captures scored against an independent cycle model.
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef SHARED_REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int         src;
    logic [7:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [7:0]    word [N];
  logic [N*DW-1:0] din;
  logic [N-1:0]  gnt;
  logic [7:0]    q;
  logic          q_valid;
  logic [1:0]    q_src;
  logic          q_ack;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;
  exp_t exp_q[$];

  assign din = {word[3], word[2], word[1], word[0]};

  always #5 clk = ~clk;

  shared_reg_arbiter #(.NREQ(N), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .q_src   (q_src),
    .q_ack   (q_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: lowest eligible index >= p, otherwise lowest overall.
  function automatic int model_pick(input logic [N-1:0] elig, input int p);
    for (int i = p; i < N; i++) if (elig[i]) return i;
    for (int i = 0; i < p; i++) if (elig[i]) return i;
    return -1;
  endfunction

  logic [7:0]   m_q;
  logic         m_valid;
  int           m_src;
  logic [N-1:0] m_gnt;
  int           m_ptr;
  logic         m_hold;
  int           m_w;
  logic [7:0]   m_word;

  assign m_w    = model_pick(req & ~m_gnt, m_ptr);
  assign m_word = (m_w < 0) ? 8'h00 : word[m_w[1:0]];

  always @(posedge clk) begin
    if (rst) begin
      m_q <= '0; m_valid <= 1'b0; m_src <= 0; m_gnt <= '0; m_ptr <= 0; m_hold <= 1'b0;
    end else begin
      m_gnt <= '0;
      if (m_w >= 0 && (!m_hold || (BYP && q_ack))) begin
        m_q     <= m_word;
        m_src   <= m_w;
        m_valid <= 1'b1;
        m_gnt   <= N'(1) << m_w;
        m_ptr   <= (m_w + 1) % N;
        m_hold  <= 1'b1;
        exp_q.push_back('{src: m_w, data: m_word});
      end else if (m_hold && q_ack) begin
        m_valid <= 1'b0;
        m_hold  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_valid", 32'(q_valid), 32'(m_valid));
      check("mon_src", 32'(q_src), 32'(m_src));
      check("mon_q", 32'(q), 32'(m_q));
      if (gnt != '0) begin
        if (exp_q.size() == 0) begin
          check("spurious_gnt", 32'(gnt), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_src", 32'(q_src), 32'(e.src));
          check("sb_data", 32'(q), 32'(e.data));
          check("sb_gnt", 32'(gnt), 32'(1 << e.src));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int src, output logic [7:0] data);
    int n;
    n = 0; src = -1; data = 8'h00;
    do begin
      tick();
      n++;
    end while (gnt == '0 && n < 20);
    if (gnt == '0) check("gnt_timeout", 32'h0, 32'h1);
    else begin
      src  = int'(q_src);
      data = q;
    end
  endtask

  task automatic release_word();
    req = '0; q_ack = 1'b1;
    tick();
    q_ack = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         src;
    logic [7:0] data;
    int         got, cyc, last_cyc;
    logic [7:0] last_q;

    rst = 1'b1; req = '0; q_ack = 1'b0;
    for (int i = 0; i < N; i++) word[i] = 8'h10 + 8'(i);
    tick(); tick();
    check("rst_q", 32'(q), 32'h0);
    check("rst_valid", 32'(q_valid), 32'h0);
    check("rst_src", 32'(q_src), 32'h0);
    check("rst_gnt", 32'(gnt), 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Fairness: all requesting, ack every valid cycle.
    req = 4'b1111; got = 0; cyc = 0; last_cyc = 0;
    while (got < 5 && cyc < 60) begin
      tick();
      cyc++;
      if (gnt != '0) begin
        check("fair_src", 32'(q_src), 32'(got % 4));
        check("fair_q", 32'(q), 32'(8'h10 + 8'(got % 4)));
        if (got > 0) check("fair_gap", 32'(cyc - last_cyc), BYP ? 32'd1 : 32'd2);
        last_cyc = cyc;
        got++;
      end
      q_ack = q_valid;
    end
    if (got < 5) check("fair_timeout", 32'(got), 32'd5);
    req = '0;
    tick();
    q_ack = 1'b0;
    tick();

    // Wrap-around: ptr=1 -> grant 2 leaves ptr=3; 0011 then wraps to 0.
    req = 4'b0100; wait_gnt(src, data); check("ptr3_src", 32'(src), 32'd2); release_word();
    req = 4'b0011; wait_gnt(src, data); check("wrap_src", 32'(src), 32'd0); release_word();
    req = 4'b0011; wait_gnt(src, data); check("wrap_ptr1", 32'(src), 32'd1); release_word();

    // Masking and bubble: req held through the ack cycle yields one capture.
    req = 4'b0001;
    tick();
    check("mask_gnt", 32'(gnt), 32'h1);
    q_ack = 1'b1;
    tick();
    check("mask_gnt_clr", 32'(gnt), 32'h0);
    check("mask_bubble", 32'(q_valid), 32'h0);
    req = '0; q_ack = 1'b0;
    tick();
    check("mask_single", 32'(q_valid), 32'h0);

    // Reset in HOLD discards the held word and resets the pointer.
    word[1] = 8'hA5;
    req = 4'b0010; wait_gnt(src, data);
    check("hold_data", 32'(data), 32'hA5);
    req = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("hrst_q", 32'(q), 32'h0);
    check("hrst_valid", 32'(q_valid), 32'h0);
    check("hrst_gnt", 32'(gnt), 32'h0);
    check("hrst_src", 32'(q_src), 32'h0);
    req = 4'b0100; wait_gnt(src, data); check("hrst_first", 32'(src), 32'd2); release_word();
    req = 4'b1011; wait_gnt(src, data); check("hrst_ptr3", 32'(src), 32'd3); release_word();

    // Withdrawal of requester 1 and stray acks while idle.
    req = 4'b0011; wait_gnt(src, data); check("wd_first", 32'(src), 32'd0);
    req = '0; q_ack = 1'b1;
    tick();
    q_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wd_no_gnt", 32'(gnt), 32'h0);
    end
    last_q = q;
    q_ack = 1'b1;
    tick(); tick();
    check("stray_valid", 32'(q_valid), 32'h0);
    check("stray_q", 32'(q), 32'(last_q));
    check("stray_gnt", 32'(gnt), 32'h0);
    q_ack = 1'b0;
    req = 4'b0100; wait_gnt(src, data); check("stray_ptr", 32'(src), 32'd2); release_word();

`ifdef SHARED_REG_BYPASS_EN
    // Back-to-back captures with ack every cycle (ptr=3 wraps to 1).
    req = 4'b0110; q_ack = 1'b1;
    tick();
    check("b2b_src1", 32'(q_src), 32'd1);
    tick();
    check("b2b_src2", 32'(q_src), 32'd2);
    check("b2b_valid", 32'(q_valid), 32'h1);
    req = '0;
    tick();
    q_ack = 1'b0;
    tick();
`endif

    // Random traffic scored entirely by the model.
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      req   = N'($urandom);
      q_ack = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 3) == 0) word[$urandom_range(0, N - 1)] = 8'($urandom);
      tick();
    end
    rst = 1'b0; req = '0; q_ack = 1'b1;
    tick(); tick();
    @(negedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter that shares one DW-bit capture register (positive-edge D flip-flops with synchronous active-high reset) between NREQ requesters. Each requester offers a data word; the block picks one winner fairly, loads its word into the shared register, and holds it valid until a downstream consumer acknowledges. The block sits between several producers and a single-register consumer port.

## Interface
- NREQ, default 4: number of requesters, at least 2.
- DW, default 8: data width of each requester word and of the shared register.
- clk  input  1  clock; all state changes on the positive edge.
- rst  input  1  synchronous reset, active-high.
- req  input  NREQ  per-requester request; held high until gnt is seen.
- din  input  NREQ*DW  packed words; requester i uses din[i*DW +: DW], held stable while req[i] is high.
- gnt  output  NREQ  one-hot, registered; one-cycle pulse on the cycle the winner's word first appears on q.
- q  output  DW  shared register contents.
- q_valid  output  1  q holds an unconsumed word.
- q_src  output  $clog2(NREQ)  index of the requester whose word is in q.
- q_ack  input  1  consumer accepts q; only meaningful while q_valid is high.

## Operation
- **Reset values:** when rst is high at a clock edge:
  - q = 0, q_valid = 0, q_src = 0, gnt = 0
  - round-robin pointer ptr = 0, state = IDLE
  - This takes priority over every other event, including mid-HOLD and the gnt cycle. The held word is discarded.
- **FSM states:** IDLE, HOLD.
- **IDLE:**
  - If any eligible req is high, the winner w is the first high req at or after ptr, scanning ptr, ptr+1, … with wrap from NREQ-1 to 0.
  - At the edge: q <= din[w], q_src <= w, q_valid <= 1, gnt <= onehot(w), ptr <= (w+1) mod NREQ, state <= HOLD.
  - No req high: stay in IDLE, all outputs hold.
- **HOLD:**
  - q, q_src and q_valid hold until q_ack is high at an edge.
  - On that edge, q_valid <= 0 and state <= IDLE (unless the macro below is defined). q keeps its last value.
  - gnt clears after its single cycle regardless of ack.
- **Eligibility:** a requester whose gnt bit is high in the current cycle is masked out of arbitration in that cycle. This prevents double capture, because the granted requester drops req only on the following cycle.
- **Request withdrawal:** a requester that drops req before it wins is simply not selected. No error is flagged.
- **q_ack while q_valid is low:** ignored.
- **Fairness:** a continuously requesting input waits at most NREQ-1 captures between grants.

## Timing
- **Request to data:** req high in IDLE cycle 0 gives q, q_valid, q_src and gnt all valid in cycle 1. Latency is one cycle.
- **Acknowledge, macro undefined:** q_ack in cycle k drops q_valid in k+1; the earliest next capture appears in k+2. This is a one-cycle bubble.
- **Acknowledge, macro defined:** q_ack in cycle k with an eligible pending req gives the next word in k+1, with q_valid staying high.
- **Throughput:**
  - Macro undefined: at most one word every 2 cycles.
  - Macro defined: one word per cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **SHARED_REG_BYPASS_EN defined:**
  - In HOLD, an edge with q_ack high and an eligible req performs the IDLE capture sequence directly (same winner selection, masking and ptr update). State stays HOLD and q_valid stays high.
  - q_ack high with no eligible req behaves as the undefined case.
- **SHARED_REG_BYPASS_EN undefined:** HOLD always returns to IDLE on ack; the one-cycle bubble is mandatory.

## Structure
- **Package shared_reg_pkg:**
  - State encoding typedef (IDLE, HOLD).
  - Default NREQ/DW constants.
  - Helper function for the pointer-width calculation.
- **Sub-module rr_pick:** combinational round-robin selector.
  - Inputs: req masked by gnt, and ptr.
  - Outputs: winner index and an any-request flag.
  - Instantiated once.
- The top module holds the FSM, ptr, and the q/q_src/q_valid/gnt registers.

## Test plan
- **Reset during HOLD:** rst high during HOLD with q=0xA5 -> next cycle q=0, q_valid=0, gnt=0; with req=4'b0100, the first capture after reset is from requester 2, and the next has ptr=3.
- **Fairness:** req=4'b1111 held, q_ack high every valid cycle, din[i]=0x10+i -> q_src sequence 0,1,2,3,0, with q values 0x10..0x13.
- **Wrap-around:** ptr=3 and req=4'b0011 -> winner 0 (wrap), ptr becomes 1.
- **Masking and bubble (macro undefined):** req=4'b0001 held one extra cycle after gnt, ack in the gnt cycle -> exactly one capture; q_valid low for one cycle before any new capture.
- **Back-to-back (SHARED_REG_BYPASS_EN defined):** req=4'b0110 with ack every cycle -> q_valid continuously high, q_src 1 then 2 on consecutive cycles.
- **Withdrawal and stray ack:** req[1] pulsed low before winning -> requester 1 never granted; q_ack pulsed while q_valid=0 -> no state change.
